parser_act_ram_ctrl: RTL and testbench

Sequencer in front of parser_do_parsing. It owns the parse-action RAM, looks up the parse-action entry for each packet's VLAN ID, and presents segments plus the entry to the parser in the same cycle. It waits for parser completion before accepting the next packet. It also arbitrates control-path writes into the same single-port RAM.

---
 rtl/parser_act_ram_ctrl.sv | 146 ++++++++++++++
 tb/tb_parser_act_ram_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parser_act_ram_ctrl.sv
// Parse-action RAM sequencer: looks up the per-VLAN parse-action entry and issues header plus
// entry to the parser. Optional counters are enabled with PARSER_ACT_STATS_EN.
module parser_act_ram_ctrl #(
    parameter int unsigned C_AXIS_DATA_WIDTH  = 512,
    parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_NUM_SEGS         = 2,
    parameter int unsigned C_PARSER_RAM_WIDTH = 160,
    parameter int unsigned C_ADDR_W           = 4
) (
    input  logic                                      axis_clk,
    input  logic                                      aresetn,
    input  logic                                      s_segs_valid,
    input  logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0]   s_tdata_segs,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]             s_tuser_1st,
    output logic                                      s_segs_ready,
    output logic                                      m_segs_valid,
    output logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0]   m_tdata_segs,
    output logic [C_AXIS_TUSER_WIDTH-1:0]             m_tuser_1st,
    output logic [C_PARSER_RAM_WIDTH-1:0]             m_bram,
    input  logic                                      parser_done,
    input  logic                                      cfg_wr_valid,
    input  logic [C_ADDR_W-1:0]                       cfg_wr_addr,
    input  logic [C_PARSER_RAM_WIDTH-1:0]             cfg_wr_data,
    output logic                                      cfg_wr_ready
`ifdef PARSER_ACT_STATS_EN
    ,
    output logic [31:0]                               stat_lookups,
    output logic [31:0]                               stat_cfg_writes
`endif
);

    localparam int unsigned SegW  = C_NUM_SEGS * C_AXIS_DATA_WIDTH;
    localparam int unsigned Depth = 1 << C_ADDR_W;

    typedef enum logic [1:0] {StIdle, StRd, StIssue, StWaitDone} state_e;

    state_e                          state_q, state_d;
    logic                            pend_valid_q;
    logic [C_ADDR_W-1:0]             pend_addr_q;
    logic [C_PARSER_RAM_WIDTH-1:0]   pend_data_q;
    logic [C_ADDR_W-1:0]             idx_q;
    logic [SegW-1:0]                 segs_q;
    logic [C_AXIS_TUSER_WIDTH-1:0]   tuser_q;
    logic [C_PARSER_RAM_WIDTH-1:0]   bram_q;
    logic                            segs_valid_q;

    logic [C_PARSER_RAM_WIDTH-1:0]   mem [Depth];
    logic [C_PARSER_RAM_WIDTH-1:0]   ram_dout;
    logic [C_ADDR_W-1:0]             ram_addr;
    logic                            ram_we;
    logic                            commit;
    logic                            seg_ready;
    logic                            hs;
    logic                            cfg_acc;

    always_comb begin
        state_d   = state_q;
        commit    = 1'b0;
        seg_ready = 1'b0;
        hs        = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A config write offered this cycle wins over a lookup.
                seg_ready = !pend_valid_q && !cfg_wr_valid;
                if (pend_valid_q) begin
                    commit = 1'b1;
                end else if (s_segs_valid && seg_ready) begin
                    hs      = 1'b1;
                    state_d = StRd;
                end
            end
            StRd:    state_d = StIssue;
            StIssue: state_d = StWaitDone;
            StWaitDone: begin
                commit = pend_valid_q;
                if (parser_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign ram_we       = commit && aresetn;
    assign ram_addr     = commit ? pend_addr_q : idx_q;
    assign cfg_wr_ready = aresetn && !pend_valid_q;
    assign s_segs_ready = aresetn && seg_ready;
    assign cfg_acc      = cfg_wr_valid && cfg_wr_ready;

    // Single-port RAM, contents deliberately not reset.
    always_ff @(posedge axis_clk) begin
        if (ram_we) mem[ram_addr] <= pend_data_q;
        ram_dout <= mem[ram_addr];
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            state_q      <= StIdle;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            idx_q        <= '0;
            segs_q       <= '0;
            tuser_q      <= '0;
            bram_q       <= '0;
            segs_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cfg_acc) begin
                pend_valid_q <= 1'b1;
                pend_addr_q  <= cfg_wr_addr;
                pend_data_q  <= cfg_wr_data;
            end else if (commit) begin
                pend_valid_q <= 1'b0;
            end
            if (hs) begin
                segs_q  <= s_tdata_segs;
                tuser_q <= s_tuser_1st;
                idx_q   <= s_tdata_segs[116 +: C_ADDR_W];
            end
            segs_valid_q <= (state_q == StIssue);
            if (state_q == StIssue) bram_q <= ram_dout;
        end
    end

    assign m_segs_valid = segs_valid_q;
    assign m_tdata_segs = segs_q;
    assign m_tuser_1st  = tuser_q;
    assign m_bram       = bram_q;

`ifdef PARSER_ACT_STATS_EN
    logic [31:0] lookups_q, writes_q;

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            lookups_q <= '0;
            writes_q  <= '0;
        end else begin
            if (state_q == StIssue) lookups_q <= lookups_q + 32'd1;
            if (ram_we)             writes_q  <= writes_q + 32'd1;
        end
    end

    assign stat_lookups    = lookups_q;
    assign stat_cfg_writes = writes_q;
`endif

endmodule

// File: tb/tb_parser_act_ram_ctrl.sv
// Directed self-checking bench for parser_act_ram_ctrl.
module tb_parser_act_ram_ctrl;

    localparam int DW = 512;
    localparam int UW = 128;
    localparam int NS = 2;
    localparam int RW = 160;
    localparam int AW = 4;
    localparam int SW = NS * DW;

    logic          axis_clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          s_segs_valid = 1'b0;
    logic [SW-1:0] s_tdata_segs = '0;
    logic [UW-1:0] s_tuser_1st = '0;
    logic          s_segs_ready;
    logic          m_segs_valid;
    logic [SW-1:0] m_tdata_segs;
    logic [UW-1:0] m_tuser_1st;
    logic [RW-1:0] m_bram;
    logic          parser_done = 1'b0;
    logic          cfg_wr_valid = 1'b0;
    logic [AW-1:0] cfg_wr_addr = '0;
    logic [RW-1:0] cfg_wr_data = '0;
    logic          cfg_wr_ready;
`ifdef PARSER_ACT_STATS_EN
    logic [31:0]   stat_lookups;
    logic [31:0]   stat_cfg_writes;
`endif

    int tests = 0;
    int fails = 0;

    localparam logic [RW-1:0] DataA5 = {20{8'hA5}};
    localparam logic [RW-1:0] DataD5 = {20{8'hD5}};
    localparam logic [RW-1:0] Data3C = {20{8'h3C}};
    localparam logic [RW-1:0] Data77 = {20{8'h77}};
    localparam logic [RW-1:0] Data88 = {20{8'h88}};
    localparam logic [RW-1:0] DataE1 = {20{8'hE1}};

    parser_act_ram_ctrl #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .C_NUM_SEGS        (NS),
        .C_PARSER_RAM_WIDTH(RW),
        .C_ADDR_W          (AW)
    ) dut (
        .axis_clk       (axis_clk),
        .aresetn        (aresetn),
        .s_segs_valid   (s_segs_valid),
        .s_tdata_segs   (s_tdata_segs),
        .s_tuser_1st    (s_tuser_1st),
        .s_segs_ready   (s_segs_ready),
        .m_segs_valid   (m_segs_valid),
        .m_tdata_segs   (m_tdata_segs),
        .m_tuser_1st    (m_tuser_1st),
        .m_bram         (m_bram),
        .parser_done    (parser_done),
        .cfg_wr_valid   (cfg_wr_valid),
        .cfg_wr_addr    (cfg_wr_addr),
        .cfg_wr_data    (cfg_wr_data),
        .cfg_wr_ready   (cfg_wr_ready)
`ifdef PARSER_ACT_STATS_EN
        ,
        .stat_lookups   (stat_lookups),
        .stat_cfg_writes(stat_cfg_writes)
`endif
    );

    always #5 axis_clk = ~axis_clk;

    function automatic logic [SW-1:0] mk_segs(input logic [11:0] vlan, input logic [31:0] seed);
        logic [SW-1:0] d;
        d = {(SW/32){seed}};
        d[116 +: 12] = vlan;
        return d;
    endfunction

    function automatic logic [UW-1:0] mk_tuser(input logic [31:0] seed);
        return {4{seed ^ 32'h5a5a_5a5a}};
    endfunction

    task automatic step;
        @(posedge axis_clk);
        #1;
    endtask

    // Returns one cycle after the handshake edge (DUT in RD).
    task automatic send_hdr(input logic [11:0] vlan, input logic [31:0] seed);
        int n;
        s_tdata_segs = mk_segs(vlan, seed);
        s_tuser_1st  = mk_tuser(seed);
        s_segs_valid = 1'b1;
        #1;
        n = 0;
        while (!s_segs_ready && n < 20) begin
            step;
            n++;
        end
        tests++;
        if (s_segs_ready !== 1'b1) begin
            fails++;
            $display("FAIL hdr_ready_timeout: s_segs_ready=%0b required 1", s_segs_ready);
        end
        step;
        s_segs_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [AW-1:0] addr, input logic [RW-1:0] data);
        int n;
        cfg_wr_valid = 1'b1;
        cfg_wr_addr  = addr;
        cfg_wr_data  = data;
        #1;
        n = 0;
        while (!cfg_wr_ready && n < 40) begin
            step;
            n++;
        end
        tests++;
        if (cfg_wr_ready !== 1'b1) begin
            fails++;
            $display("FAIL cfg_ready_timeout: cfg_wr_ready=%0b required 1", cfg_wr_ready);
        end
        step;
        cfg_wr_valid = 1'b0;
    endtask

    task automatic lookup(input logic [11:0] vlan, input logic [31:0] seed,
                          input logic [RW-1:0] exp);
        send_hdr(vlan, seed);
        step;
        tests++;
        if (m_segs_valid !== 1'b0) begin
            fails++;
            $display("FAIL lat_early vlan=%0h: m_segs_valid=%0b required 0", vlan, m_segs_valid);
        end
        step;
        tests++;
        if (m_segs_valid !== 1'b1 || m_bram !== exp) begin
            fails++;
            $display("FAIL lookup vlan=%0h: valid=%0b bram=%h required valid=1 bram=%h",
                     vlan, m_segs_valid, m_bram, exp);
        end
        tests++;
        if (m_tdata_segs !== mk_segs(vlan, seed) || m_tuser_1st !== mk_tuser(seed)) begin
            fails++;
            $display("FAIL lookup_data vlan=%0h: tuser=%h required %h",
                     vlan, m_tuser_1st, mk_tuser(seed));
        end
        parser_done = 1'b1;
        step;
        parser_done = 1'b0;
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        step;
        step;
        tests++;
        if (m_segs_valid !== 1'b0 || m_bram !== '0 || m_tdata_segs !== '0 ||
            m_tuser_1st !== '0 || s_segs_ready !== 1'b0 || cfg_wr_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: valid=%0b ready=%0b cfg_ready=%0b required all 0",
                     m_segs_valid, s_segs_ready, cfg_wr_ready);
        end
        aresetn = 1'b1;
        #1;
        tests++;
        if (s_segs_ready !== 1'b1 || cfg_wr_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: s_segs_ready=%0b cfg_wr_ready=%0b required 1 1",
                     s_segs_ready, cfg_wr_ready);
        end
    endtask

    task automatic test_basic;
        cfg_write(4'd3, DataA5);
        lookup(12'h003, 32'h1234_5678, DataA5);
    endtask

    task automatic test_cfg_priority;
        cfg_wr_valid = 1'b1;
        cfg_wr_addr  = 4'd5;
        cfg_wr_data  = DataD5;
        s_tdata_segs = mk_segs(12'h005, 32'hCAFE_0005);
        s_tuser_1st  = mk_tuser(32'hCAFE_0005);
        s_segs_valid = 1'b1;
        #1;
        tests++;
        if (s_segs_ready !== 1'b0 || cfg_wr_ready !== 1'b1) begin
            fails++;
            $display("FAIL prio_same_cycle: s_segs_ready=%0b cfg_wr_ready=%0b required 0 1",
                     s_segs_ready, cfg_wr_ready);
        end
        step;
        cfg_wr_valid = 1'b0;
        #1;
        tests++;
        if (s_segs_ready !== 1'b0) begin
            fails++;
            $display("FAIL prio_pending: s_segs_ready=%0b required 0", s_segs_ready);
        end
        step;
        tests++;
        if (s_segs_ready !== 1'b1) begin
            fails++;
            $display("FAIL prio_after_commit: s_segs_ready=%0b required 1", s_segs_ready);
        end
        step;
        s_segs_valid = 1'b0;
        step;
        step;
        tests++;
        if (m_segs_valid !== 1'b1 || m_bram !== DataD5) begin
            fails++;
            $display("FAIL prio_lookup: valid=%0b bram=%h required 1 %h",
                     m_segs_valid, m_bram, DataD5);
        end
        parser_done = 1'b1;
        step;
        parser_done = 1'b0;
    endtask

    task automatic test_hold;
        int  pulses;
        bit  stable_ok;
        bit  ready_ok;
        pulses    = 0;
        stable_ok = 1'b1;
        ready_ok  = 1'b1;
        // parser_done held across IDLE and RD must be ignored.
        parser_done = 1'b1;
        step;
        send_hdr(12'h003, 32'h0BAD_F00D);
        step;
        parser_done = 1'b0;
        for (int i = 0; i < 22; i++) begin
            if (i == 3) begin
                cfg_wr_valid = 1'b1;
                cfg_wr_addr  = 4'd3;
                cfg_wr_data  = Data3C;
            end
            step;
            if (i == 3) cfg_wr_valid = 1'b0;
            if (m_segs_valid === 1'b1) pulses++;
            if (s_segs_ready !== 1'b0) ready_ok = 1'b0;
            if (m_bram !== DataA5 || m_tdata_segs !== mk_segs(12'h003, 32'h0BAD_F00D) ||
                m_tuser_1st !== mk_tuser(32'h0BAD_F00D)) stable_ok = 1'b0;
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL hold_pulses: pulses=%0d required 1", pulses);
        end
        tests++;
        if (!stable_ok) begin
            fails++;
            $display("FAIL hold_stable: bram=%h required %h", m_bram, DataA5);
        end
        tests++;
        if (!ready_ok) begin
            fails++;
            $display("FAIL hold_ready: s_segs_ready went %0b required 0", 1'b1);
        end
        parser_done = 1'b1;
        step;
        parser_done = 1'b0;
        lookup(12'h003, 32'h0000_3333, Data3C);
    endtask

    task automatic test_back_to_back;
        send_hdr(12'h005, 32'h5555_0001);
        cfg_wr_valid = 1'b1;
        cfg_wr_addr  = 4'd7;
        cfg_wr_data  = Data77;
        #1;
        tests++;
        if (cfg_wr_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_first_ready: cfg_wr_ready=%0b required 1", cfg_wr_ready);
        end
        step;
        cfg_wr_addr = 4'd8;
        cfg_wr_data = Data88;
        #1;
        tests++;
        if (cfg_wr_ready !== 1'b0) begin
            fails++;
            $display("FAIL b2b_issue_ready: cfg_wr_ready=%0b required 0", cfg_wr_ready);
        end
        step;
        tests++;
        if (cfg_wr_ready !== 1'b0 || m_segs_valid !== 1'b1) begin
            fails++;
            $display("FAIL b2b_wait_ready: cfg_wr_ready=%0b valid=%0b required 0 1",
                     cfg_wr_ready, m_segs_valid);
        end
        step;
        tests++;
        if (cfg_wr_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_after_commit: cfg_wr_ready=%0b required 1", cfg_wr_ready);
        end
        step;
        cfg_wr_valid = 1'b0;
        #1;
        tests++;
        if (cfg_wr_ready !== 1'b0) begin
            fails++;
            $display("FAIL b2b_second_pend: cfg_wr_ready=%0b required 0", cfg_wr_ready);
        end
        step;
        tests++;
        if (cfg_wr_ready !== 1'b1 || m_bram !== DataD5) begin
            fails++;
            $display("FAIL b2b_second_commit: cfg_wr_ready=%0b bram=%h required 1 %h",
                     cfg_wr_ready, m_bram, DataD5);
        end
        parser_done = 1'b1;
        step;
        parser_done = 1'b0;
        lookup(12'h007, 32'h7777_0007, Data77);
        lookup(12'h008, 32'h8888_0008, Data88);
    endtask

`ifdef PARSER_ACT_STATS_EN
    task automatic test_stats;
        tests++;
        if (stat_cfg_writes !== 32'd5 || stat_lookups !== 32'd7) begin
            fails++;
            $display("FAIL stats: writes=%0d lookups=%0d required 5 7",
                     stat_cfg_writes, stat_lookups);
        end
    endtask
`endif

    task automatic test_reset_mid;
        int pulses;
        pulses = 0;
        send_hdr(12'h003, 32'hDEAD_0003);
        cfg_wr_valid = 1'b1;
        cfg_wr_addr  = 4'd3;
        cfg_wr_data  = DataE1;
        step;
        cfg_wr_valid = 1'b0;
        step;
        tests++;
        if (m_segs_valid !== 1'b1) begin
            fails++;
            $display("FAIL rmid_pulse: m_segs_valid=%0b required 1", m_segs_valid);
        end
        aresetn = 1'b0;
        step;
        tests++;
        if (m_segs_valid !== 1'b0 || m_bram !== '0 || m_tdata_segs !== '0 ||
            m_tuser_1st !== '0 || s_segs_ready !== 1'b0 || cfg_wr_ready !== 1'b0) begin
            fails++;
            $display("FAIL rmid_outputs: valid=%0b bram=%h required 0 0", m_segs_valid, m_bram);
        end
        aresetn = 1'b1;
        #1;
        tests++;
        if (s_segs_ready !== 1'b1) begin
            fails++;
            $display("FAIL rmid_ready: s_segs_ready=%0b required 1", s_segs_ready);
        end
        for (int i = 0; i < 5; i++) begin
            step;
            if (m_segs_valid === 1'b1) pulses++;
        end
        tests++;
        if (pulses != 0) begin
            fails++;
            $display("FAIL rmid_stray: pulses=%0d required 0", pulses);
        end
        // The pending 0xE1 write was dropped by reset.
        lookup(12'h003, 32'h4444_0003, Data3C);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_cfg_priority;
        test_hold;
        test_back_to_back;
`ifdef PARSER_ACT_STATS_EN
        test_stats;
`endif
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
